// File: rtl/seizure_vote_pkg.sv
// Shared constants, state type and popcount helper for the seizure vote block.
// Imported by seizure_window_collect and seizure_vote.
package seizure_pkg;

    localparam int NUM_FEAT  = 6;
    localparam int FEAT_LL    = 0;
    localparam int FEAT_NE    = 1;
    localparam int FEAT_PS    = 2;
    localparam int FEAT_THETA = 3;
    localparam int FEAT_ALPHA = 4;
    localparam int FEAT_BETA  = 5;

    localparam int COUNT_W   = 3;
    localparam int PERSIST_W = 4;
    localparam int HOLD_W    = 8;

    typedef enum logic {
        ARMED = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic logic [COUNT_W-1:0] popcount(input logic [NUM_FEAT-1:0] v);
        logic [COUNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_FEAT; i++) begin
            c = c + {{(COUNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/seizure_window_collect.sv
// Collects per-feature window results, flags completion/overrun; optional timeout (SEIZURE_VOTE_TIMEOUT_EN).
// Latency: win_done/win_count are combinational in the completion cycle; overrun/timeout_err registered.
// Backpressure: none; a repeated strobe overwrites the stored flag and raises sticky overrun.
module seizure_window_collect
    import seizure_pkg::*;
#(
    parameter logic [NUM_FEAT-1:0] FEAT_MASK = 6'b111111,
    parameter int                  TIMEOUT   = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_FEAT-1:0] bin_vec,
    input  logic [NUM_FEAT-1:0] vld_vec,
    output logic                win_done,
    output logic [COUNT_W-1:0]  win_count,
    output logic                overrun,
    output logic                timeout_err
);

    logic [NUM_FEAT-1:0] seen_q, hit_q;
    logic [NUM_FEAT-1:0] stb, seen_nxt, hit_nxt;
    logic                expire;

    assign stb      = vld_vec & FEAT_MASK;
    assign seen_nxt = seen_q | stb;
    assign hit_nxt  = (hit_q & ~stb) | (bin_vec & stb);
    // An empty mask would otherwise complete every cycle; treat it as never complete.
    assign win_done  = (FEAT_MASK != '0) && ((seen_nxt & FEAT_MASK) == FEAT_MASK);
    assign win_count = popcount(hit_nxt & FEAT_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q  <= '0;
            hit_q   <= '0;
            overrun <= 1'b0;
        end else begin
            if (|(stb & seen_q)) begin
                overrun <= 1'b1;
            end
            if (win_done || expire) begin
                seen_q <= '0;
                hit_q  <= '0;
            end else begin
                seen_q <= seen_nxt;
                hit_q  <= hit_nxt;
            end
        end
    end

`ifdef SEIZURE_VOTE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr_q;

    // Counter reads 1 after the first strobe, so expiry fires TIMEOUT cycles later.
    assign expire = (seen_q != '0) && !win_done && (tmr_q == TW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= expire;
            if (win_done || expire) begin
                tmr_q <= '0;
            end else if (seen_nxt != '0) begin
                tmr_q <= tmr_q + 1'b1;
            end
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: rtl/seizure_vote.sv
// Per-window feature vote with persistence alarm and holdoff; optional window timeout (SEIZURE_VOTE_TIMEOUT_EN).
// Latency: vote_valid/alarm one cycle after the last strobe completing a window.
// Backpressure: none; strobes are always accepted, early repeats set sticky overrun.
module seizure_vote
    import seizure_pkg::*;
#(
    parameter int                  VOTE_K    = 4,
    parameter int                  PERSIST   = 3,
    parameter int                  HOLDOFF   = 16,
    parameter logic [NUM_FEAT-1:0] FEAT_MASK = 6'b111111,
    parameter int                  TIMEOUT   = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ll_binary,
    input  logic               ne_binary,
    input  logic               ps_binary,
    input  logic               theta_binary,
    input  logic               alpha_binary,
    input  logic               beta_binary,
    input  logic               ll_valid,
    input  logic               ne_valid,
    input  logic               ps_valid,
    input  logic               theta_valid,
    input  logic               alpha_valid,
    input  logic               beta_valid,
    output logic               vote_valid,
    output logic [COUNT_W-1:0] vote_count,
    output logic               window_hit,
    output logic               alarm,
    output logic               holdoff_active,
    output logic               overrun,
    output logic               timeout_err
);

    logic [NUM_FEAT-1:0] bin_vec, vld_vec;
    logic                win_done;
    logic [COUNT_W-1:0]  win_count;

    assign bin_vec = {beta_binary, alpha_binary, theta_binary, ps_binary, ne_binary, ll_binary};
    assign vld_vec = {beta_valid, alpha_valid, theta_valid, ps_valid, ne_valid, ll_valid};

    seizure_window_collect #(
        .FEAT_MASK (FEAT_MASK),
        .TIMEOUT   (TIMEOUT)
    ) u_collect (
        .clk         (clk),
        .rst_n       (rst_n),
        .bin_vec     (bin_vec),
        .vld_vec     (vld_vec),
        .win_done    (win_done),
        .win_count   (win_count),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    state_t                state_q, state_d;
    logic [PERSIST_W-1:0]  persist_q, persist_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  hit_now, alarm_d;

    assign hit_now = int'(win_count) >= VOTE_K;

    always_comb begin
        state_d   = state_q;
        persist_d = persist_q;
        hold_d    = hold_q;
        alarm_d   = 1'b0;
        if (win_done) begin
            case (state_q)
                ARMED: begin
                    if (!hit_now) begin
                        persist_d = '0;
                    end else if (int'(persist_q) + 1 >= PERSIST) begin
                        alarm_d   = 1'b1;
                        persist_d = '0;
                        if (HOLDOFF != 0) begin
                            hold_d  = HOLD_W'(HOLDOFF);
                            state_d = HOLD;
                        end
                    end else begin
                        persist_d = persist_q + 1'b1;
                    end
                end
                HOLD: begin
                    hold_d = hold_q - 1'b1;
                    if (hold_q == HOLD_W'(1)) begin
                        state_d = ARMED;
                    end
                end
                default: state_d = ARMED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARMED;
            persist_q  <= '0;
            hold_q     <= '0;
            vote_valid <= 1'b0;
            vote_count <= '0;
            window_hit <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state_q    <= state_d;
            persist_q  <= persist_d;
            hold_q     <= hold_d;
            vote_valid <= win_done;
            window_hit <= win_done && hit_now;
            alarm      <= alarm_d;
            if (win_done) begin
                vote_count <= win_count;
            end
        end
    end

    assign holdoff_active = (state_q == HOLD);

endmodule

// File: tb/tb_seizure_vote.sv
// Scoreboard bench for seizure_vote: stimulus pushes expected votes from a window-level model, a monitor pops and compares.
module tb_seizure_vote;

    localparam int         VOTE_K  = 4;
    localparam int         PERSIST = 3;
    localparam int         HOLDOFF = 16;
    localparam int         TIMEOUT = 8;
    localparam logic [5:0] MASK    = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] bin = '0;
    logic [5:0] vld = '0;
    logic       vote_valid, window_hit, alarm, holdoff_active, overrun, timeout_err;
    logic [2:0] vote_count;

    always #5 clk = ~clk;

    seizure_vote #(
        .VOTE_K    (VOTE_K),
        .PERSIST   (PERSIST),
        .HOLDOFF   (HOLDOFF),
        .FEAT_MASK (MASK),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ll_binary      (bin[0]),
        .ne_binary      (bin[1]),
        .ps_binary      (bin[2]),
        .theta_binary   (bin[3]),
        .alpha_binary   (bin[4]),
        .beta_binary    (bin[5]),
        .ll_valid       (vld[0]),
        .ne_valid       (vld[1]),
        .ps_valid       (vld[2]),
        .theta_valid    (vld[3]),
        .alpha_valid    (vld[4]),
        .beta_valid     (vld[5]),
        .vote_valid     (vote_valid),
        .vote_count     (vote_count),
        .window_hit     (window_hit),
        .alarm          (alarm),
        .holdoff_active (holdoff_active),
        .overrun        (overrun),
        .timeout_err    (timeout_err)
    );

    typedef struct packed {
        logic [2:0] cnt;
        logic       hit;
        logic       alarm;
        logic       hold;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   m_persist = 0;
    int   m_hold = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Window-level reference: count, hit threshold, persistence run length, holdoff windows left.
    task automatic model_window(input logic [5:0] bits);
        int   c;
        exp_t e;
        c       = $countones(bits & MASK);
        e.cnt   = 3'(c);
        e.hit   = (c >= VOTE_K);
        e.alarm = 1'b0;
        if (m_hold > 0) begin
            m_hold--;
        end else if (e.hit) begin
            m_persist++;
            if (m_persist == PERSIST) begin
                e.alarm   = 1'b1;
                m_persist = 0;
                m_hold    = HOLDOFF;
            end
        end else begin
            m_persist = 0;
        end
        e.hold = (m_hold > 0);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (vote_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_vote", {vote_count, window_hit, alarm, holdoff_active}, 32'hffff_ffff);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("vote", {vote_count, window_hit, alarm, holdoff_active}, mon_e);
`ifndef SEIZURE_VOTE_TIMEOUT_EN
                    chk("timeout_err_tied", timeout_err, 0);
`endif
                end
            end else if (alarm) begin
                chk("alarm_without_vote", alarm, 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [5:0] sel, input logic [5:0] bits);
        vld = sel;
        bin = bits;
        @(posedge clk);
        #1;
        vld = '0;
    endtask

    // Full window, each feature strobed once in a random cycle within 0..spread.
    task automatic send_window(input logic [5:0] bits, input int spread);
        int slot[6];
        int last;
        last = 0;
        for (int i = 0; i < 6; i++) begin
            slot[i] = $urandom_range(0, spread);
            if (slot[i] > last) last = slot[i];
        end
        model_window(bits);
        for (int c = 0; c <= last; c++) begin
            for (int i = 0; i < 6; i++) vld[i] = (slot[i] == c);
            bin = bits;
            @(posedge clk);
            #1;
        end
        vld = '0;
    endtask

    task automatic do_reset(input string tag);
        idle(1);
        chk({tag, "_votes_drained"}, exp_q.size(), 0);
        rst_n = 1'b0;
        vld   = '0;
        #2;
        chk({tag, "_reset_outputs"},
            {vote_valid, vote_count, window_hit, alarm, holdoff_active, overrun, timeout_err}, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_persist = 0;
        m_hold    = 0;
        exp_q.delete();
        idle(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [5:0] r;
        int         seen_at;

        do_reset("initial");

        // Single-cycle window, four features high.
        send_window(6'b001111, 0);
        idle(2);
        chk("overrun_clear", overrun, 0);

        // Persistence alarm, 16 held windows, rebuild to a second alarm.
        do_reset("persist");
        for (int w = 0; w < 22; w++) send_window(6'b011111, 2);
        idle(2);

        // Miss in the middle breaks the run.
        do_reset("miss");
        send_window(6'b111100, 1);
        send_window(6'b111100, 1);
        send_window(6'b000111, 1);
        send_window(6'b111100, 1);
        send_window(6'b111100, 1);
        send_window(6'b111111, 1);
        idle(2);

        // Reset mid-window: pre-reset strobes must not carry over.
        do_reset("midwin");
        strobe(6'b000001, 6'b111111);
        strobe(6'b000010, 6'b111111);
        strobe(6'b000100, 6'b111111);
        do_reset("midwin_rst");
        model_window(6'b110001);
        strobe(6'b111000, 6'b110001);
        idle(3);
        strobe(6'b000111, 6'b110001);
        idle(2);
        chk("midwin_no_overrun", overrun, 0);

        // Repeated ll strobe: last value wins, overrun sticks.
        do_reset("overrun");
        strobe(6'b000001, 6'b000001);
        strobe(6'b000001, 6'b000000);
        chk("overrun_set", overrun, 1);
        model_window(6'b001110);
        strobe(6'b111110, 6'b001110);
        send_window(6'b101011, 1);
        idle(2);
        chk("overrun_sticky", overrun, 1);

`ifdef SEIZURE_VOTE_TIMEOUT_EN
        // Incomplete window times out without touching persistence.
        do_reset("timeout");
        send_window(6'b111111, 0);
        send_window(6'b111111, 0);
        idle(1);
        vld = 6'b011111;
        bin = 6'b011111;
        @(posedge clk);
        #1;
        vld = '0;
        seen_at = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (timeout_err && seen_at < 0) seen_at = k;
            @(posedge clk);
            #1;
        end
        chk("timeout_cycle", seen_at, 8);
        send_window(6'b111111, 0);
        idle(2);
`endif

        // Randomised windows biased toward hits so alarms and holdoff occur.
        do_reset("random");
        for (int w = 0; w < 200; w++) begin
            r = 6'($urandom);
            if ($urandom_range(0, 3) != 0) r = r | 6'(6'b001111 << $urandom_range(0, 2));
            send_window(r, $urandom_range(0, 3));
            idle($urandom_range(0, 2));
        end
        idle(4);
        chk("final_votes_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
